// File: rtl/step_dir_decoder.sv
// step_dir_decoder: synchronised, deglitched STEP/DIR receiver with signed position,
// step period measurement, motion timeout and target match.
module step_dir_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN = 4,
  parameter int PERIOD_W = 24,
  parameter int unsigned TIMEOUT = 10_000_000
) (
  input  logic                clk100m,
  input  logic                rst,
  input  logic                step_in,
  input  logic                dir_in,
  input  logic                en,
  input  logic                clr,
  input  logic                load,
  input  logic [31:0]         load_val,
  input  logic [31:0]         target,
  input  logic                target_en,
  output logic [31:0]         pos,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                moving,
  output logic                match,
  output logic                overflow
);
  logic [SYNC_STAGES-1:0] r_step_s, r_dir_s;
  logic [FILT_LEN-1:0] r_step_h, r_dir_h;
  logic r_step_f, r_step_fd, r_dir_f, r_first, r_pv, r_moving, r_match, r_ovf;
  logic [31:0] r_pos;
  logic [PERIOD_W-1:0] r_cnt, r_period;
  logic w_ev, w_ovf;
  logic [31:0] w_pos_step;
  logic [PERIOD_W-1:0] w_cnt_inc;
  always_comb begin
    w_ev = en && r_step_f && !r_step_fd && !clr && !load;
    w_pos_step = r_dir_f ? r_pos + 32'd1 : r_pos - 32'd1;
    w_ovf = r_dir_f ? (r_pos == 32'h7fff_ffff) : (r_pos == 32'h8000_0000);
    w_cnt_inc = (r_cnt != '0 && r_cnt != '1) ? r_cnt + PERIOD_W'(1) : r_cnt;
  end
  always_ff @(posedge clk100m) begin
    if (rst) begin
      {r_step_s, r_dir_s, r_step_h, r_dir_h} <= '0;
      {r_step_f, r_step_fd, r_dir_f, r_first, r_pv, r_moving, r_match, r_ovf} <= '0;
      {r_pos, r_cnt, r_period} <= '0;
    end else begin
      r_step_s <= SYNC_STAGES'({r_step_s, step_in});
      r_dir_s <= SYNC_STAGES'({r_dir_s, dir_in});
      r_step_h <= FILT_LEN'({r_step_h, r_step_s[SYNC_STAGES-1]});
      r_dir_h <= FILT_LEN'({r_dir_h, r_dir_s[SYNC_STAGES-1]});
      // level flips only once the whole history window agrees on the new value
      r_step_f <= &r_step_h ? 1'b1 : (|r_step_h ? r_step_f : 1'b0);
      r_dir_f <= &r_dir_h ? 1'b1 : (|r_dir_h ? r_dir_f : 1'b0);
      r_step_fd <= r_step_f;
      r_pv <= w_ev && r_first;
      r_match <= target_en && (load ? load_val == target : w_ev && w_pos_step == target);
      r_pos <= load ? load_val : (w_ev ? w_pos_step : r_pos);
      r_ovf <= r_ovf || (w_ev && w_ovf);
      r_cnt <= w_ev ? PERIOD_W'(1) : w_cnt_inc;
      if (w_ev && r_first) r_period <= r_cnt;
      r_first <= r_first || w_ev;
      r_moving <= w_ev || (r_moving && r_cnt != PERIOD_W'(TIMEOUT));
      if (clr) begin
        {r_pos, r_cnt, r_period} <= '0;
        {r_ovf, r_moving, r_first, r_match} <= '0;
      end
    end
  end
  assign pos = r_pos;
  assign period = r_period;
  assign period_valid = r_pv;
  assign moving = r_moving;
  assign match = r_match;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_step_dir_decoder.sv
// tb_step_dir_decoder: directed scenarios with a position scoreboard checked on every pos change.
module tb_step_dir_decoder;
  logic clk100m = 0, rst = 1, step_in = 0, dir_in = 0, en = 0, clr = 0, load = 0, target_en = 0;
  logic [31:0] load_val = 0, target = 0;
  logic [31:0] pos;
  logic [23:0] period;
  logic period_valid, moving, match, overflow;
  int vectors = 0, miscompares = 0, n_pv = 0, n_match = 0, lat;
  logic [31:0] match_pos = 0, prev = 0, exp_pos;
  logic [31:0] q[$];

  always #5 clk100m = ~clk100m;

  step_dir_decoder #(.TIMEOUT(200)) dut (
    .clk100m(clk100m), .rst(rst), .step_in(step_in), .dir_in(dir_in), .en(en),
    .clr(clr), .load(load), .load_val(load_val), .target(target), .target_en(target_en),
    .pos(pos), .period(period), .period_valid(period_valid), .moving(moving),
    .match(match), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk100m);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    step_in = 1;
    tick(hi);
    step_in = 0;
    tick(lo);
  endtask

  task automatic pulse_load(input logic [31:0] v);
    load_val = v;
    load = 1;
    tick(1);
    load = 0;
  endtask

  task automatic pulse_clr();
    clr = 1;
    tick(1);
    clr = 0;
  endtask

  // every pos change must match the oldest outstanding expectation
  always @(negedge clk100m) begin
    if (period_valid === 1'b1) n_pv++;
    if (match === 1'b1) begin
      n_match++;
      match_pos = pos;
    end
    if (pos !== prev) begin
      exp_pos = (q.size() != 0) ? q.pop_front() : prev;
      chk("pos_update", pos, exp_pos);
      prev = pos;
    end
  end

  initial begin
    tick(3);
    rst = 0;
    tick(1);
    chk("rst_pos", pos, 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_flags", {28'd0, period_valid, moving, match, overflow}, 0);

    en = 1;
    dir_in = 1;
    n_pv = 0;
    tick(10);
    for (int i = 1; i <= 10; i++) begin
      q.push_back(32'(i));
      pulse(10, 10);
    end
    tick(10);
    chk("up10_pos", pos, 10);
    chk("up10_period", 32'(period), 20);
    chk("up10_pv_count", 32'(n_pv), 9);
    chk("up10_moving", 32'(moving), 1);
    tick(200);
    chk("timeout_moving", 32'(moving), 0);
    chk("timeout_period", 32'(period), 20);

    q.push_back(0);
    pulse_clr();
    dir_in = 0;
    tick(10);
    chk("clr_period", 32'(period), 0);
    for (int i = 1; i <= 5; i++) begin
      q.push_back(32'(-i));
      pulse(10, 10);
    end
    tick(10);
    chk("down5_pos", pos, 32'hffff_fffb);

    dir_in = 1;
    tick(10);
    pulse(3, 10);
    pulse(1, 10);
    tick(10);
    chk("glitch_pos", pos, 32'hffff_fffb);
    q.push_back(32'hffff_fffc);
    step_in = 1;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk100m);
      #1;
      if (k == 4) step_in = 0;
      if (lat < 0 && pos !== 32'hffff_fffb) lat = k - 1;
    end
    chk("latency", 32'(lat), 7);
    tick(10);

    q.push_back(0);
    pulse_load(0);
    target = 3;
    target_en = 1;
    n_match = 0;
    tick(2);
    for (int i = 1; i <= 5; i++) begin
      q.push_back(32'(i));
      pulse(10, 10);
    end
    tick(10);
    chk("match_count_steps", 32'(n_match), 1);
    chk("match_pos", match_pos, 3);
    q.push_back(3);
    pulse_load(3);
    tick(2);
    chk("match_count_load", 32'(n_match), 2);
    target_en = 0;

    q.push_back(32'h7fff_fffe);
    pulse_load(32'h7fff_fffe);
    tick(2);
    q.push_back(32'h7fff_ffff);
    pulse(10, 10);
    q.push_back(32'h8000_0000);
    pulse(10, 10);
    q.push_back(32'h8000_0001);
    pulse(10, 10);
    tick(10);
    chk("ovf_pos", pos, 32'h8000_0001);
    chk("ovf_set", 32'(overflow), 1);
    q.push_back(5);
    pulse_load(5);
    tick(2);
    chk("ovf_after_load", 32'(overflow), 1);
    q.push_back(0);
    pulse_clr();
    chk("ovf_clr", 32'(overflow), 0);
    chk("ovf_clr_period", 32'(period), 0);
    tick(2);

    q.push_back(1);
    pulse(10, 10);
    tick(10);
    n_pv = 0;
    q.push_back(0);
    step_in = 1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk100m);
      #1;
      if (k == 4) step_in = 0;
      if (k == 7) clr = 1;
    end
    clr = 0;
    tick(10);
    chk("clr_ev_pos", pos, 0);
    chk("clr_ev_pv", 32'(n_pv), 0);
    chk("clr_ev_moving", 32'(moving), 0);

    q.push_back(1);
    pulse(10, 10);
    q.push_back(2);
    pulse(10, 10);
    step_in = 1;
    tick(3);
    q.push_back(0);
    rst = 1;
    tick(1);
    chk("midrst_pos", pos, 0);
    chk("midrst_period", 32'(period), 0);
    chk("midrst_flags", {28'd0, period_valid, moving, match, overflow}, 0);
    rst = 0;
    step_in = 0;
    tick(20);
    chk("post_rst_pos", pos, 0);
    chk("queue_empty", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/step_dir_decoder.md
# step_dir_decoder

Single-channel step/direction pulse decoder: the receiving end of the stepper PWM/DIR interface our pulse generators drive. It synchronises and deglitches external STEP and DIR lines, keeps a signed position count, measures the step period, and flags a programmable target position. Instances sit beside the PWM channels, wired to loopback or encoder-emulation inputs, and their outputs are read through the AHB register block.

## Interface
- SYNC_STAGES, 2, synchroniser flops on step_in/dir_in (≥2)
- FILT_LEN, 4, consecutive equal samples required to accept a level change (≥1)
- PERIOD_W, 24, period counter / period output width
- TIMEOUT, 24'd10_000_000, cycles without a step before moving drops (≤ 2^PERIOD_W-1)

- clk100m  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- step_in  in  1  asynchronous STEP line, rising edge = one step
- dir_in  in  1  asynchronous DIR line, 1 = +1, 0 = -1
- en  in  1  1 = count steps; 0 = ignore step events
- clr  in  1  pulse: clear position, period and status
- load  in  1  pulse: pos <= load_val
- load_val  in  32  signed preload value
- target  in  32  signed match position
- target_en  in  1  enables match
- pos  out  32  signed position, two's complement
- period  out  PERIOD_W  cycles between last two accepted steps
- period_valid  out  1  one-cycle pulse when period updates
- moving  out  1  step seen within last TIMEOUT cycles
- match  out  1  one-cycle pulse when pos becomes equal to target
- overflow  out  1  sticky: pos wrapped past ±2^31

## Operation
- Synchroniser: SYNC_STAGES flops per input; reset value 0.
- Filter (separately per line): filtered level changes only when the last FILT_LEN synchronised samples all differ from the current filtered level. Pulses shorter than FILT_LEN cycles are rejected. Filters run regardless of en.
- Step event: rising edge of filtered STEP while en=1. At the event, filtered DIR selects +1 or -1.
- Position update priority, per cycle: clr > load > step event.
  - clr: pos, overflow, period and moving go to 0, and the first-step flag clears. A step event in the same cycle is discarded.
  - load: pos <= load_val. A step event in the same cycle is discarded; overflow is unaffected.
- Overflow: set when +1 takes pos from 0x7FFFFFFF to 0x80000000, or -1 takes it from 0x80000000 to 0x7FFFFFFF. pos wraps. Only clr or rst clears overflow.
- Period counter:
  - Reset/clr value 0. Set to 1 on the cycle after each step event, then increments each cycle, saturating at 2^PERIOD_W-1.
  - On a step event with the first-step flag set: period <= counter and period_valid pulses.
  - The first step after rst/clr only sets the flag.
- moving: set on a step event. Cleared when the counter reaches TIMEOUT or on clr. period holds its value on timeout.
- match: pulses for one cycle on the cycle pos is written with a value equal to target while target_en=1. This covers step updates and load. It does not fire while pos merely stays equal, or when target changes.
- Reset values: all outputs 0.

## Timing
- Latency: fixed at SYNC_STAGES+FILT_LEN+1 cycles from the first clk100m edge that samples step_in high to the pos update (7 with defaults). period_valid and match assert in the same cycle pos changes. moving rises in that cycle as well.
- DIR setup: dir_in must be stable from at least SYNC_STAGES+FILT_LEN cycles before the step_in rise until the event.
- Maximum accepted step rate: high ≥ FILT_LEN and low ≥ FILT_LEN cycles (12.5 MHz with defaults).
- clr/load act on the next clock edge; outputs reflect them one cycle later.
- Step events with en=0 do not update pos, period or moving. Re-asserting en while STEP is already high does not create an event.

## Test plan
- 10 pulses, dir_in=1, 10 high / 10 low cycles, en=1 → pos=10, period=20, exactly 9 period_valid pulses, moving=1; then idle TIMEOUT cycles → moving=0, period still 20.
- From clr, 5 pulses with dir_in=0 → pos=0xFFFFFFFB (-5).
- Glitch rejection: 3-cycle and 1-cycle highs on step_in → pos unchanged; a 4-cycle high → pos+1, latency exactly 7 cycles.
- target=3, target_en=1, 5 up-steps → a single match pulse, coincident with pos=3; load with load_val=3 → a second match pulse.
- load_val=0x7FFFFFFE, 3 up-steps → pos=0x80000001, overflow=1; the next load leaves overflow=1; clr → overflow=0, pos=0.
- clr in the same cycle as a step event → pos=0 and no period_valid pulse; rst asserted mid-burst → all outputs 0 on the next cycle.
